muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the stage-2 ALU of the 3-stage core.
- Stage-2 control raises start for OPC_ARI_RTYPE instructions with funct7 = 0000001.
- The unit stalls stages 1-2 until the result is ready.
- The result is muxed into the stage-2 ALU-result path.
- The unit computes 1 bit per cycle: radix-2 shift-add for multiply, restoring division for divide.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_seq_if.sv | 22 ++
 rtl/muldiv_sign_fix.sv | 32 +++
 rtl/muldiv_seq.sv | 142 ++++++++++++++
 tb/tb_muldiv_seq.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the RV32M iterative multiply/divide unit:
// funct3/funct7 encodings, FSM state type and operand helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Stage-2 decode helper: R-type with this funct7 belongs to the M extension.
  function automatic logic is_mext(input logic [6:0] funct7);
    return funct7 == FNC7_MULDIV;
  endfunction

  // Two's-complement magnitude; 0x8000_0000 maps to itself (read as unsigned).
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Handshake/operand bundle between stage-2 control and the M-extension unit.
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Final result formation: reapply the sign to the unsigned magnitudes and
// select low/high product word or quotient/remainder by funct3.
module muldiv_sign_fix
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] mag,
  input  logic [XLEN-1:0]   rem,
  input  logic              neg,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic signed [2*XLEN-1:0] prod_s;
  logic signed [XLEN-1:0]   quo_s;
  logic signed [XLEN-1:0]   rem_s;

  always_comb begin
    prod_s = neg ? -$signed(mag) : $signed(mag);
    quo_s  = neg ? -$signed(mag[XLEN-1:0]) : $signed(mag[XLEN-1:0]);
    rem_s  = neg ? -$signed(rem) : $signed(rem);
    result = rem_s;
    unique case (funct3)
      FNC_MUL:                        result = prod_s[XLEN-1:0];
      FNC_MULH, FNC_MULHSU, FNC_MULHU: result = prod_s[2*XLEN-1:XLEN];
      FNC_DIV, FNC_DIVU:              result = quo_s;
      default:                        result = rem_s;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, radix-2 shift-add
// multiply and restoring divide, with its own IDLE/RUN/DONE sequencer.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_e     state_q, state_d;
  logic [2:0]        fn_q, fn_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;

  logic              signed_a, signed_b, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_step, quo_step;
  logic [XLEN-1:0]   fix_res;

  // Operand classification at accept time.
  assign signed_a = (bus.funct3 != FNC_MULHU) && (bus.funct3 != FNC_DIVU) &&
                    (bus.funct3 != FNC_REMU);
  assign signed_b = signed_a && (bus.funct3 != FNC_MULHSU);
  assign a_neg    = signed_a & bus.op_a[XLEN-1];
  assign b_neg    = signed_b & bus.op_b[XLEN-1];
  assign div_zero = bus.funct3[2] && (bus.op_b == '0);
  assign div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                    (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

  // One iteration step; a_q doubles as dividend and quotient shift register.
  assign acc_step = b_q[0] ? acc_q + ({{XLEN{1'b0}}, a_q} << cnt_q) : acc_q;
  assign rem_sh   = {rem_q, a_q[XLEN-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  assign rem_step = rem_ge ? rem_sh[XLEN-1:0] - b_q : rem_sh[XLEN-1:0];
  assign quo_step = {a_q[XLEN-2:0], rem_ge};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .mag    (fn_q[2] ? {{XLEN{1'b0}}, quo_step} : acc_step),
    .rem    (rem_step),
    .neg    (neg_q),
    .funct3 (fn_q),
    .result (fix_res)
  );

  always_comb begin
    state_d  = state_q;
    fn_d     = fn_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          fn_d  = bus.funct3;
          a_d   = mag32(bus.op_a, a_neg);
          b_d   = mag32(bus.op_b, b_neg);
          neg_d = (bus.funct3 == FNC_REM) ? a_neg : (a_neg ^ b_neg);
          acc_d = '0;
          rem_d = '0;
          cnt_d = '0;
          if (div_zero) begin
            state_d  = DONE;
            result_d = bus.funct3[1] ? bus.op_a : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = bus.funct3[1] ? '0 : bus.op_a;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (fn_q[2]) begin
            a_d   = quo_step;
            rem_d = rem_step;
          end else begin
            acc_d = acc_step;
            b_d   = b_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            result_d = fix_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fn_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fn_q     <= fn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);
  assign bus.stall  = bus.start & ~bus.done;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, stall, special
// cases, flush abort and asynchronous reset mid-operation.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op and wait for done; lat counts cycles from the accept cycle.
  task automatic do_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input bit wait_edge,
                       input bit keep, input string tag);
    int lat;
    int stall_cnt;
    bit seen;
    if (wait_edge) @(negedge clk);
    bus.start  = is_mext(FNC7_MULDIV);
    bus.funct3 = fn;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
    stall_cnt = bus.stall ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (lat < 60 && !seen) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1'b1;
      else if (bus.stall) stall_cnt++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, bus.result, exp);
    check_val({tag, "_stallcyc"}, stall_cnt, wait_edge ? exp_lat : exp_lat - 1);
    check_val({tag, "_stall_at_done"}, {31'b0, bus.stall}, 32'd0);
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    int done_seen;
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",   {31'b0, bus.busy},  32'd0);
    check_val("rst_done",   {31'b0, bus.done},  32'd0);
    check_val("rst_stall",  {31'b0, bus.stall}, 32'd0);
    check_val("rst_result", bus.result,         32'd0);
    rst_n = 1'b1;

    do_op(FNC_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1, 0, "mul_7_m3");
    do_op(FNC_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1, 0, "mulh_7_m3");
    do_op(FNC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, 0, "mulhu_max");
    do_op(FNC_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1, 0, "mulhsu_m1");
    do_op(FNC_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 33, 1, 0, "div_m20_6");
    do_op(FNC_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33, 1, 0, "rem_m20_6");
    do_op(FNC_DIVU,   32'd100,        32'd7,         32'd14,        33, 1, 0, "divu_100_7");
    do_op(FNC_DIVU,   32'd123,        32'd0,         32'hFFFF_FFFF, 1,  1, 0, "divu_by0");
    do_op(FNC_REM,    32'd123,        32'd0,         32'd123,       1,  1, 0, "rem_by0");
    do_op(FNC_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1, 0, "rem_ovf");
    do_op(FNC_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1, 0, "div_ovf");

    // flush in IDLE blocks acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = FNC_MUL; bus.op_a = 32'd2; bus.op_b = 32'd2;
    repeat (3) @(negedge clk);
    check_val("idle_flush_busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.flush = 1'b0;

    // flush in RUN at count 10
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = FNC_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    done_seen = 0;
    repeat (11) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check_val("run_busy_before_flush", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    check_val("flush_busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (40) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check_val("flush_no_done", done_seen, 32'd0);
    check_val("flush_result_kept", bus.result, 32'h8000_0000);

    do_op(FNC_MUL, 32'd3, 32'd5, 32'd15, 33, 1, 0, "mul_3_5");

    // async reset at RUN count 20
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = FNC_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
    repeat (21) @(negedge clk);
    check_val("run_busy_before_rst", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy",   {31'b0, bus.busy}, 32'd0);
    check_val("midrst_done",   {31'b0, bus.done}, 32'd0);
    check_val("midrst_result", bus.result,        32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back: second done 34 cycles after the first
    do_op(FNC_MUL,  32'd6,    32'd7,  32'd42,  33, 1, 1, "b2b_mul");
    do_op(FNC_DIVU, 32'd1000, 32'd10, 32'd100, 34, 0, 0, "b2b_divu");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
